// File: rtl/eeprom_pkg.sv
// Shared state encoding and defaults for the two-wire EEPROM responder.
package eeprom_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_CTRL      = 4'd1,
        ST_CTRL_ACK  = 4'd2,
        ST_ADDR      = 4'd3,
        ST_ADDR_ACK  = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_WAIT_STOP = 4'd9
    } state_t;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam logic [3:0]  DEV_ID_DEF = 4'b1010;
    localparam int unsigned PAGE_W_DEF = 4;

    localparam logic SDA_ACK  = 1'b0;
    localparam logic SDA_NACK = 1'b1;

    function automatic logic dev_match(input logic [7:0] ctrl, input logic [3:0] id);
        return (ctrl[7:4] == id);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizer for SCL/SDA with edge register; produces SCL edge
// strobes and START/STOP strobes one cycle wide.
module i2c_bus_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Synchronizer and previous-sample registers; bus idles high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign sda_o      = sda_sync_q[1];
    assign scl_rise_o =  scl_sync_q[1] & ~scl_prev_q;
    assign scl_fall_o = ~scl_sync_q[1] &  scl_prev_q;
    // SCL must be high in both samples, so an SDA edge coinciding with an SCL edge is data.
    assign start_o    = scl_sync_q[1] & scl_prev_q &  sda_prev_q & ~sda_sync_q[1];
    assign stop_o     = scl_sync_q[1] & scl_prev_q & ~sda_prev_q &  sda_sync_q[1];

endmodule

// File: rtl/eeprom_i2c_slave.sv
// Two-wire serial EEPROM responder with a 2**ADDR_W x 8 array.
// Optional write-protect input enabled by defining EEPROM_SLV_WP_EN.
module eeprom_i2c_slave
    import eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter logic [3:0]  DEV_ID = DEV_ID_DEF,
    parameter int unsigned PAGE_W = PAGE_W_DEF
) (
    input  logic CLK,
    input  logic RESET,
    input  logic SCL,
    inout  wire  SDA,
`ifdef EEPROM_SLV_WP_EN
    input  logic WP,
`endif
    output logic BUSY
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [PAGE_W-1:0] PAGE_ONE = {{(PAGE_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [3:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              sda_low_q;
    logic              busy_q;
    logic              mack_q;

    logic              sda_s;
    logic              scl_rise_s;
    logic              scl_fall_s;
    logic              start_s;
    logic              stop_s;
    logic              wp_s;
    logic              mem_we_s;
    logic [7:0]        rd_byte_s;
    logic [ADDR_W-1:0] ptr_page_inc_s;
    logic [ADDR_W-1:0] ptr_full_inc_s;

    logic [7:0]        mem_q [0:(2**ADDR_W)-1];

    i2c_bus_sync u_sync (
        .clk_i      (CLK),
        .rst_n_i    (RESET),
        .scl_i      (SCL),
        .sda_i      (SDA),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise_s),
        .scl_fall_o (scl_fall_s),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

`ifdef EEPROM_SLV_WP_EN
    assign wp_s = WP;
`else
    assign wp_s = 1'b0;
`endif

    assign SDA  = sda_low_q ? 1'b0 : 1'bz;
    assign BUSY = busy_q;

    assign ptr_page_inc_s = {ptr_q[ADDR_W-1:PAGE_W], ptr_q[PAGE_W-1:0] + PAGE_ONE};
    assign ptr_full_inc_s = ptr_q + PTR_ONE;
    assign rd_byte_s      = mem_q[ptr_q];
    assign mem_we_s       = scl_fall_s && (state_q == ST_WDATA_ACK) && !wp_s;

    // Array write port; contents survive reset.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_q[ptr_q] <= shift_q;
        end
    end

    // Protocol FSM: bus conditions take priority over SCL edges.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'h00;
            ptr_q     <= {ADDR_W{1'b0}};
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
            mack_q    <= 1'b0;
        end else if (stop_s) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (start_s) begin
            state_q   <= ST_CTRL;
            bit_cnt_q <= 4'd0;
            sda_low_q <= 1'b0;
            busy_q    <= 1'b1;
        end else if (scl_rise_s) begin
            case (state_q)
                ST_CTRL, ST_ADDR, ST_WDATA: begin
                    shift_q   <= {shift_q[6:0], sda_s};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                ST_RDATA: begin
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
                ST_RDATA_ACK: begin
                    mack_q <= (sda_s == SDA_ACK);
                    if (sda_s == SDA_ACK) begin
                        ptr_q <= ptr_full_inc_s;
                    end
                end
                default: begin
                end
            endcase
        end else if (scl_fall_s) begin
            case (state_q)
                ST_CTRL: begin
                    if (bit_cnt_q == 4'd8) begin
                        if (dev_match(shift_q, DEV_ID)) begin
                            ptr_q[ADDR_W-1:8] <= shift_q[ADDR_W-8:1];
                            mack_q            <= shift_q[0];
                            sda_low_q         <= 1'b1;
                            state_q           <= ST_CTRL_ACK;
                        end else begin
                            sda_low_q <= 1'b0;
                            state_q   <= ST_WAIT_STOP;
                        end
                    end
                end
                ST_CTRL_ACK: begin
                    bit_cnt_q <= 4'd0;
                    // mack_q holds the R/W bit here; first read bit goes out on this edge.
                    if (mack_q) begin
                        shift_q   <= rd_byte_s;
                        sda_low_q <= ~rd_byte_s[7];
                        state_q   <= ST_RDATA;
                    end else begin
                        sda_low_q <= 1'b0;
                        state_q   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bit_cnt_q == 4'd8) begin
                        ptr_q[7:0] <= shift_q;
                        sda_low_q  <= 1'b1;
                        state_q    <= ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    bit_cnt_q <= 4'd0;
                    sda_low_q <= 1'b0;
                    state_q   <= ST_WDATA;
                end
                ST_WDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_low_q <= 1'b1;
                        state_q   <= ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    ptr_q     <= ptr_page_inc_s;
                    bit_cnt_q <= 4'd0;
                    sda_low_q <= 1'b0;
                    state_q   <= ST_WDATA;
                end
                ST_RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_low_q <= 1'b0;
                        state_q   <= ST_RDATA_ACK;
                    end else begin
                        shift_q   <= {shift_q[6:0], 1'b0};
                        sda_low_q <= ~shift_q[6];
                    end
                end
                ST_RDATA_ACK: begin
                    bit_cnt_q <= 4'd0;
                    if (mack_q) begin
                        shift_q   <= rd_byte_s;
                        sda_low_q <= ~rd_byte_s[7];
                        state_q   <= ST_RDATA;
                    end else begin
                        sda_low_q <= 1'b0;
                        state_q   <= ST_WAIT_STOP;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eeprom_i2c_slave.sv
// Scoreboard bench for eeprom_i2c_slave: bus tasks queue expected bytes/bits,
// a monitor process compares them against what the bus actually shows.
module tb_eeprom_i2c_slave;

    typedef struct {
        string      name;
        logic [7:0] val;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    logic scl_r;
    logic sda_low_r;
    logic busy_w;
    wire  sda_w;
`ifdef EEPROM_SLV_WP_EN
    logic wp_r;
`endif

    item_t      exp_q[$];
    logic [7:0] obs_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    assign sda_w = sda_low_r ? 1'b0 : 1'bz;
    pullup (sda_w);

    always #5 clk = ~clk;

    eeprom_i2c_slave dut (
        .CLK   (clk),
        .RESET (rst_n),
        .SCL   (scl_r),
        .SDA   (sda_w),
`ifdef EEPROM_SLV_WP_EN
        .WP    (wp_r),
`endif
        .BUSY  (busy_w)
    );

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string nm, input logic [7:0] v);
        item_t it;
        it.name = nm;
        it.val  = v;
        exp_q.push_back(it);
    endtask

    task automatic observe(input logic [7:0] v);
        obs_q.push_back(v);
    endtask

    task automatic chk(input string nm, input logic got, input logic want);
        expect_v(nm, {7'd0, want});
        observe({7'd0, got});
    endtask

    // SCL is low on entry and on exit of every bit task.
    task automatic send_bit(input logic b);
        wclk(5);
        sda_low_r = ~b;
        wclk(5);
        scl_r = 1'b1;
        wclk(10);
        scl_r = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        wclk(5);
        sda_low_r = 1'b0;
        wclk(5);
        scl_r = 1'b1;
        wclk(5);
        b = sda_w;
        wclk(5);
        scl_r = 1'b0;
    endtask

    task automatic i2c_start();
        if (scl_r == 1'b0) begin
            wclk(5);
            sda_low_r = 1'b0;
            wclk(5);
            scl_r = 1'b1;
            wclk(10);
        end
        sda_low_r = 1'b1;
        wclk(10);
        scl_r = 1'b0;
    endtask

    task automatic i2c_stop();
        wclk(5);
        sda_low_r = 1'b1;
        wclk(5);
        scl_r = 1'b1;
        wclk(10);
        sda_low_r = 1'b0;
        wclk(10);
    endtask

    task automatic write_byte(input string nm, input logic [7:0] d, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i]);
        end
        expect_v({nm, "_ack"}, {7'd0, exp_ack});
        recv_bit(a);
        observe({7'd0, a});
    endtask

    task automatic read_byte(input string nm, input logic [7:0] exp_d, input logic mack);
        logic [7:0] d;
        logic       b;
        expect_v(nm, exp_d);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        observe(d);
        send_bit(mack ? 1'b0 : 1'b1);
    endtask

    task automatic read_setup(input string nm, input logic [7:0] cw, input logic [7:0] adr);
        i2c_start();
        write_byte({nm, "_cw"}, cw, 1'b0);
        write_byte({nm, "_adr"}, adr, 1'b0);
        i2c_start();
        write_byte({nm, "_cr"}, cw | 8'h01, 1'b0);
    endtask

    // Scoreboard monitor: pairs each observation with the oldest expectation.
    initial begin : monitor
        item_t      it;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            while (obs_q.size() > 0) begin
                got = obs_q.pop_front();
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected: got %h, nothing expected", got);
                end else begin
                    it = exp_q.pop_front();
                    if (got !== it.val) begin
                        n_fail++;
                        $display("FAIL %s: got %h, required %h", it.name, got, it.val);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst_n     = 1'b0;
        scl_r     = 1'b1;
        sda_low_r = 1'b0;
`ifdef EEPROM_SLV_WP_EN
        wp_r      = 1'b0;
`endif
        wclk(3);
        chk("rst_busy", busy_w, 1'b0);
        chk("rst_sda", sda_w, 1'b1);
        rst_n = 1'b1;
        wclk(3);

        // Byte write 8'hA5 to 11'h123, then random read it back.
        i2c_start();
        chk("t1_busy_on", busy_w, 1'b1);
        write_byte("t1_ctl", 8'hA2, 1'b0);
        write_byte("t1_adr", 8'h23, 1'b0);
        write_byte("t1_dat", 8'hA5, 1'b0);
        i2c_stop();
        chk("t1_busy_off", busy_w, 1'b0);
        read_setup("t1r", 8'hA2, 8'h23);
        read_byte("t1_rd", 8'hA5, 1'b0);
        i2c_stop();

        // Foreign device type: never acknowledged, bus stays busy until STOP.
        i2c_start();
        write_byte("t2_ctl", 8'hB0, 1'b1);
        write_byte("t2_b1", 8'h23, 1'b1);
        write_byte("t2_b2", 8'h5A, 1'b1);
        chk("t2_busy_hold", busy_w, 1'b1);
        i2c_stop();
        chk("t2_busy_off", busy_w, 1'b0);
        read_setup("t2r", 8'hA2, 8'h23);
        read_byte("t2_rd", 8'hA5, 1'b0);
        i2c_stop();

        // Page write crossing the 16-byte page boundary wraps to 11'h010.
        i2c_start();
        write_byte("t3_ctl", 8'hA0, 1'b0);
        write_byte("t3_adr", 8'h1E, 1'b0);
        write_byte("t3_d0", 8'h11, 1'b0);
        write_byte("t3_d1", 8'h22, 1'b0);
        write_byte("t3_d2", 8'h33, 1'b0);
        i2c_stop();
        read_setup("t3r", 8'hA0, 8'h1E);
        read_byte("t3_rd01e", 8'h11, 1'b1);
        read_byte("t3_rd01f", 8'h22, 1'b0);
        i2c_stop();
        read_setup("t3s", 8'hA0, 8'h10);
        read_byte("t3_rd010", 8'h33, 1'b0);
        i2c_stop();

        // Sequential read wraps from 11'h7FF to 11'h000.
        i2c_start();
        write_byte("t4_ctl_a", 8'hAE, 1'b0);
        write_byte("t4_adr_a", 8'hFF, 1'b0);
        write_byte("t4_dat_a", 8'h3C, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte("t4_ctl_b", 8'hA0, 1'b0);
        write_byte("t4_adr_b", 8'h00, 1'b0);
        write_byte("t4_dat_b", 8'hC3, 1'b0);
        i2c_stop();
        read_setup("t4r", 8'hAE, 8'hFF);
        read_byte("t4_rd7ff", 8'h3C, 1'b1);
        read_byte("t4_rd000", 8'hC3, 1'b0);
        wclk(6);
        chk("t4_released", sda_w, 1'b1);
        i2c_stop();

        // Reset while the slave drives a 0 data bit.
        read_setup("t5r", 8'hA0, 8'h1E);
        wclk(6);
        chk("t5_driving", sda_w, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("t5_sda_z", sda_w, 1'b1);
        chk("t5_busy_rst", busy_w, 1'b0);
        scl_r = 1'b1;
        wclk(3);
        rst_n = 1'b1;
        wclk(3);
        read_setup("t5a", 8'hA0, 8'h1E);
        read_byte("t5_rd01e", 8'h11, 1'b0);
        i2c_stop();
        read_setup("t5b", 8'hA2, 8'h23);
        read_byte("t5_rd123", 8'hA5, 1'b0);
        i2c_stop();

`ifdef EEPROM_SLV_WP_EN
        // Protected write is acknowledged but not committed.
        i2c_start();
        write_byte("t6_ctl0", 8'hA0, 1'b0);
        write_byte("t6_adr0", 8'h40, 1'b0);
        write_byte("t6_dat0", 8'h00, 1'b0);
        i2c_stop();
        wp_r = 1'b1;
        i2c_start();
        write_byte("t6_ctl1", 8'hA0, 1'b0);
        write_byte("t6_adr1", 8'h40, 1'b0);
        write_byte("t6_dat1", 8'h5A, 1'b0);
        i2c_stop();
        wp_r = 1'b0;
        read_setup("t6r", 8'hA0, 8'h40);
        read_byte("t6_rd040", 8'h00, 1'b0);
        i2c_stop();
`endif

        for (int i = 0; i < 50 && obs_q.size() > 0; i++) begin
            wclk(1);
        end
        wclk(2);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected items never observed, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/eeprom_i2c_slave.md
# eeprom_i2c_slave

Behavioural-synthesizable responder for the two-wire serial EEPROM bus: the device end that the EEPROM write/read controller talks to. Oversamples SCL/SDA on the system clock, decodes START/STOP, control, word-address and data bytes, and holds a 2 K x 8 array addressed by an 11-bit address. Used as the on-chip target in controller simulations and as a synthesizable memory model on FPGA bring-up boards.

## Interface
- ADDR_W, 11, byte address width; array depth 2**ADDR_W
- DEV_ID, 4'b1010, control-byte device-type field (bits 7:4)
- PAGE_W, 4, write page size 2**PAGE_W bytes
- CLK  input  1  system clock, at least 8x SCL frequency
- RESET  input  1  asynchronous, active-low reset
- SCL  input  1  serial clock from the controller
- SDA  inout  1  serial data, open drain: driven 0 or Z only
- BUSY  output  1  high from detected START until detected STOP
- WP  input  1  write protect (present only with EEPROM_SLV_WP_EN)

## Operation
- Framing: control byte = DEV_ID, A[10:8], R/W. Write: control(W), word address A[7:0], data bytes. Random read: control(W), word address, repeated START, control(R), data bytes.
- States: IDLE, CTRL, CTRL_ACK, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START (SDA fall while SCL high) in any state -> CTRL, bit counter cleared. STOP (SDA rise while SCL high) in any state -> IDLE; SDA released.
- Bits sampled on SCL rising edge, MSB first; SDA changes only after SCL falling edge.
- CTRL: bits[7:4] != DEV_ID -> no ACK, WAIT_STOP (ignore until next START/STOP). Match: ACK; A[10:8] latched into address pointer; R/W=0 -> ADDR, R/W=1 -> RDATA.
- ADDR: byte loaded into pointer[7:0], ACK, -> WDATA.
- WDATA: each byte ACKed, written to array[pointer] at the end of its ACK bit (9th SCL falling edge); pointer[PAGE_W-1:0] increments and wraps inside the page, upper bits unchanged. Repeated START from WDATA before any data byte = random-read setup; no write.
- RDATA: drive array[pointer] MSB first; after 8th bit release SDA, -> RDATA_ACK. Controller ACK (SDA low at 9th rising edge): pointer increments over full range (2047 -> 0), next byte. NACK: -> WAIT_STOP.
- ACK = SDA driven 0 from SCL falling edge after bit 8 until next SCL falling edge.
- Reset: state IDLE, SDA released (Z) immediately, pointer 0, BUSY 0; array contents not cleared.

## Timing
- SCL/SDA pass a 2-flop synchronizer plus edge register: event-to-action latency 3 CLK.
- SDA driven or released within 3 CLK of SCL falling edge; must not change while SCL is high except via STOP/START from controller.
- Array write occurs 3 CLK after the 9th SCL falling edge of a data byte; readable on the next read transaction with no write-cycle busy period (no ACK polling required).
- BUSY asserts/deasserts 3 CLK after START/STOP on the bus.
- Simultaneous SCL and SDA transitions in the same CLK sample: treated as data, not START/STOP.

## Configuration
- EEPROM_SLV_WP_EN defined: WP port exists; with WP=1, data bytes are still ACKed but not committed; pointer still increments.
- Undefined: no WP port; writes always commit.

## Structure
- eeprom_pkg: state enum, DEV_ID default, ACK/NACK constants, PAGE_W default.
- Sub-module i2c_bus_sync: synchronizer, SCL rise/fall strobes, START/STOP strobes.

## Test plan
- Write 8'hA5 to 11'h123, then random read 11'h123 -> controller reads 8'hA5; three slave ACKs on write, three on read setup.
- Control byte 8'hB0 -> no ACK (SDA high at 9th bit), BUSY stays high until STOP, array unchanged.
- Page write 3 bytes 11, 22, 33 starting 11'h01E -> array[01E]=11, [01F]=22, [010]=33 (page wrap).
- Sequential read from 11'h7FF, two bytes with controller ACK then NACK -> array[7FF], array[000]; SDA released after NACK.
- RESET low mid-RDATA while slave drives 0 -> SDA Z within 1 CLK, state IDLE, next START/read works, data preserved.
- With EEPROM_SLV_WP_EN, WP=1, write 8'h5A to 11'h040 (old 8'h00) -> ACKed, read returns 8'h00.
